// File: rtl/rb_steer_pipe.sv
// rb_steer_pipe: registered, handshaked row-buffer steering stage.
//
// Sits between the row-buffer BRAM read port and the window/kernel datapath.
// Each beat carries one pixel from each of NUM_RB physical row buffers. The
// rotation offset of the oldest row is tracked internally, so out_data is
// always ordered oldest row (lane 0) to newest row (lane NUM_RB-1). Each beat
// is also tagged with out_last (last column of its row) and out_primed (the
// beat belongs to a row index >= NUM_RB-1, i.e. the window is full).
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   frame_start         synchronous clear of offset, column and row tracking
//   in_valid/in_ready   input handshake; in_data lane k = physical buffer k
//   out_valid/out_ready output handshake
//   out_data            steered lanes, oldest row in lane 0
//   out_last, out_primed per-beat row-end and window-primed tags
//
// Configuration macro RB_STEER_SKID_EN:
//   defined   - 2-entry skid buffer, in_ready driven straight from a register
//   undefined - single output register, in_ready = !out_valid || out_ready
module rb_steer_pipe #(
  parameter int unsigned NUM_RB      = 3,
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned ROW_PIXELS  = 640
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          frame_start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_RB*PIXEL_WIDTH-1:0] in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_RB*PIXEL_WIDTH-1:0] out_data,
  output logic                          out_last,
  output logic                          out_primed
);

  localparam int unsigned OffW  = (NUM_RB > 1) ? $clog2(NUM_RB) : 1;
  localparam int unsigned ColW  = (ROW_PIXELS > 1) ? $clog2(ROW_PIXELS) : 1;
  localparam int unsigned DataW = NUM_RB * PIXEL_WIDTH;
  // Beat word: {last, primed, data}
  localparam int unsigned BeatW = DataW + 2;

  localparam logic [OffW-1:0] OffMax = OffW'(NUM_RB - 1);
  localparam logic [ColW-1:0] ColMax = ColW'(ROW_PIXELS - 1);

  if (NUM_RB < 2 || NUM_RB > 16) begin : gen_bad_num_rb
    $error("rb_steer_pipe: NUM_RB must be in 2..16");
  end
  if (ROW_PIXELS < 2 || ROW_PIXELS > 4096) begin : gen_bad_row_pixels
    $error("rb_steer_pipe: ROW_PIXELS must be in 2..4096");
  end

  // ---------------------------------------------------------------------------
  // Row/column/offset tracking
  // ---------------------------------------------------------------------------
  logic [OffW-1:0] off_q, off_d, off_cur;
  logic [ColW-1:0] col_q, col_d, col_cur;
  // rows saturates at NUM_RB-1, so it fits in the offset width
  logic [OffW-1:0] rows_q, rows_d, rows_cur;

  logic accept;
  logic beat_last;
  logic beat_primed;

  assign accept = in_valid && in_ready;

  always_comb begin
    // A beat accepted together with frame_start is column 0 of the new frame
    off_cur  = frame_start ? '0 : off_q;
    col_cur  = frame_start ? '0 : col_q;
    rows_cur = frame_start ? '0 : rows_q;

    beat_last   = (col_cur == ColMax);
    beat_primed = (rows_cur == OffMax);

    off_d  = off_cur;
    col_d  = col_cur;
    rows_d = rows_cur;

    if (accept) begin
      if (beat_last) begin
        col_d = '0;
        off_d = (off_cur == OffMax) ? '0 : off_cur + OffW'(1);
        if (!beat_primed) begin
          rows_d = rows_cur + OffW'(1);
        end
      end else begin
        col_d = col_cur + ColW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q  <= '0;
      col_q  <= '0;
      rows_q <= '0;
    end else begin
      off_q  <= off_d;
      col_q  <= col_d;
      rows_q <= rows_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Lane steering: out lane i = in lane (i + off) mod NUM_RB. The modulo is on
  // loop constants only, so this unrolls into one NUM_RB:1 mux per lane.
  // ---------------------------------------------------------------------------
  logic [DataW-1:0] steered;

  always_comb begin
    steered = '0;
    for (int i = 0; i < NUM_RB; i++) begin
      for (int o = 0; o < NUM_RB; o++) begin
        if (off_cur == OffW'(o)) begin
          steered[i*PIXEL_WIDTH +: PIXEL_WIDTH] =
              in_data[((i + o) % NUM_RB)*PIXEL_WIDTH +: PIXEL_WIDTH];
        end
      end
    end
  end

  logic [BeatW-1:0] beat_in;
  assign beat_in = {beat_last, beat_primed, steered};

  // ---------------------------------------------------------------------------
  // Output buffering
  // ---------------------------------------------------------------------------
  logic             main_valid_q;
  logic [BeatW-1:0] main_beat_q;

`ifdef RB_STEER_SKID_EN
  // Skid register catches a beat accepted while the main register is stalled.
  // in_ready only falls once both entries hold a beat, and comes from a flop.
  logic             skid_valid_q;
  logic [BeatW-1:0] skid_beat_q;
  logic             main_free;

  assign in_ready  = !skid_valid_q;
  assign main_free = !main_valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_beat_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_beat_q  <= '0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // in_ready is low here, so no new beat can arrive this cycle
        main_valid_q <= 1'b1;
        main_beat_q  <= skid_beat_q;
        skid_valid_q <= 1'b0;
      end else begin
        main_valid_q <= accept;
        if (accept) begin
          main_beat_q <= beat_in;
        end
      end
    end else if (accept) begin
      skid_valid_q <= 1'b1;
      skid_beat_q  <= beat_in;
    end
  end
`else
  assign in_ready = !main_valid_q || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_beat_q  <= '0;
    end else if (accept) begin
      main_valid_q <= 1'b1;
      main_beat_q  <= beat_in;
    end else if (out_ready) begin
      main_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid  = main_valid_q;
  assign out_last   = main_beat_q[BeatW-1];
  assign out_primed = main_beat_q[BeatW-2];
  assign out_data   = main_beat_q[DataW-1:0];

endmodule

// File: tb/tb_rb_steer_pipe.sv
// Self-checking bench for rb_steer_pipe. Instance a uses the default bench
// configuration (3 lanes, 8 bits, 4-pixel rows) with a queue-based reference
// model; instance b (5 lanes, 10 bits, 2-pixel rows) checks offset cycling.
module tb_rb_steer_pipe;

  localparam int NRB = 3;
  localparam int PW  = 8;
  localparam int RP  = 4;
  localparam int DW  = NRB * PW;

  localparam int NRB_B = 5;
  localparam int PW_B  = 10;
  localparam int RP_B  = 2;
  localparam int DW_B  = NRB_B * PW_B;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic          frame_start, in_valid, in_ready, out_valid, out_ready, out_last, out_primed;
  logic [DW-1:0] in_data, out_data;

  logic            fs_b, iv_b, ir_b, ov_b, or_b, ol_b, op_b;
  logic [DW_B-1:0] id_b, od_b;

  rb_steer_pipe #(.NUM_RB(NRB), .PIXEL_WIDTH(PW), .ROW_PIXELS(RP)) dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(frame_start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_primed (out_primed)
  );

  rb_steer_pipe #(.NUM_RB(NRB_B), .PIXEL_WIDTH(PW_B), .ROW_PIXELS(RP_B)) dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_start(fs_b),
    .in_valid   (iv_b),
    .in_ready   (ir_b),
    .in_data    (id_b),
    .out_valid  (ov_b),
    .out_ready  (or_b),
    .out_data   (od_b),
    .out_last   (ol_b),
    .out_primed (op_b)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          primed;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];
  int    n_beat = 0;     // beats accepted since last frame start / reset
  int    acc_cnt = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;

  // Reference rotation: output lane i carries input lane (i + off) mod nrb
  function automatic logic [159:0] steer(input logic [159:0] d, input int nrb, input int pw,
                                         input int off);
    logic [159:0] r;
    r = '0;
    for (int i = 0; i < nrb; i++) begin
      for (int b = 0; b < pw; b++) begin
        r[i*pw + b] = d[((i + off) % nrb)*pw + b];
      end
    end
    return r;
  endfunction

  // One clock of instance a: drive at negedge, sample 1 ns later.
  task automatic cycle_a(input logic iv, input logic [DW-1:0] d, input logic ordy,
                         input logic fs);
    beat_t        e, o;
    logic [159:0] s;
    int           row;
    @(negedge clk);
    in_valid    = iv;
    in_data     = d;
    frame_start = fs;
`ifdef RB_STEER_SKID_EN
    begin : blk_rdy
      logic r0;
      out_ready = 1'b0;
      #1 r0 = in_ready;
      out_ready = 1'b1;
      #1 check_eq("in_ready_vs_out_ready", in_ready, r0);
    end
`endif
    out_ready = ordy;
    #1;
    o = '{data: out_data, last: out_last, primed: out_primed};
    if (prev_stall) begin
      check_eq("stall_valid", out_valid, 1'b1);
      check_eq("stall_beat", o, prev_beat);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_out", out_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check_eq("out_data", o.data, e.data);
        check_eq("out_last", o.last, e.last);
        check_eq("out_primed", o.primed, e.primed);
        obs_q.push_back(o);
      end
    end
    if (fs) n_beat = 0;
    if (iv && in_ready) begin
      row      = n_beat / RP;
      s        = steer({136'd0, d}, NRB, PW, row % NRB);
      e.data   = s[DW-1:0];
      e.last   = ((n_beat % RP) == RP - 1);
      e.primed = (row >= NRB - 1);
      exp_q.push_back(e);
      n_beat++;
      acc_cnt++;
    end
    prev_stall = out_valid && !out_ready;
    prev_beat  = o;
  endtask

  task automatic drain_a();
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) cycle_a(1'b0, '0, 1'b1, 1'b0);
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  localparam logic [DW-1:0] Pat = 24'hC2B1A0;

  initial begin
    int           start, guard;
    logic [DW-1:0] d0;
    logic [159:0] sb;
    logic [DW_B-1:0] hist_b[12];

    frame_start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    fs_b = 1'b0; iv_b = 1'b0; id_b = '0; or_b = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #11;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_out_last", out_last, 1'b0);
    check_eq("rst_out_primed", out_primed, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;

    // 16 contiguous beats: rotation per row, wrap at row 3, primed saturation
    obs_q.delete();
    for (int j = 0; j < 16; j++) cycle_a(1'b1, Pat, 1'b1, 1'b0);
    drain_a();
    check_eq("p1_count", obs_q.size(), 16);
    if (obs_q.size() == 16) begin
      check_eq("p1_row0_data", obs_q[0].data, 24'hC2B1A0);
      check_eq("p1_row1_data", obs_q[4].data, 24'hA0C2B1);
      check_eq("p1_row2_data", obs_q[8].data, 24'hB1A0C2);
      check_eq("p1_row3_wrap", obs_q[12].data, 24'hC2B1A0);
      check_eq("p1_last_b3", obs_q[2].last, 1'b0);
      check_eq("p1_last_b4", obs_q[3].last, 1'b1);
      check_eq("p1_last_b8", obs_q[7].last, 1'b1);
      check_eq("p1_last_b12", obs_q[11].last, 1'b1);
      check_eq("p1_primed_b8", obs_q[7].primed, 1'b0);
      check_eq("p1_primed_b9", obs_q[8].primed, 1'b1);
      check_eq("p1_primed_b16", obs_q[15].primed, 1'b1);
    end

    // frame_start together with an accepted beat at row 2 column 2
    cycle_a(1'b0, '0, 1'b1, 1'b1);
    obs_q.delete();
    for (int j = 0; j < 10; j++) cycle_a(1'b1, Pat, 1'b1, 1'b0);
    cycle_a(1'b1, Pat, 1'b1, 1'b1);
    for (int j = 0; j < 4; j++) cycle_a(1'b1, Pat, 1'b1, 1'b0);
    drain_a();
    check_eq("fs_count", obs_q.size(), 15);
    if (obs_q.size() == 15) begin
      check_eq("fs_before_data", obs_q[9].data, 24'hB1A0C2);
      check_eq("fs_before_primed", obs_q[9].primed, 1'b1);
      check_eq("fs_beat_data", obs_q[10].data, 24'hC2B1A0);
      check_eq("fs_beat_primed", obs_q[10].primed, 1'b0);
      check_eq("fs_beat_last", obs_q[10].last, 1'b0);
      check_eq("fs_row_end_early", obs_q[12].last, 1'b0);
      check_eq("fs_row_end", obs_q[13].last, 1'b1);
    end

    // Random data, random in_valid and 50% out_ready over 64 beats
    cycle_a(1'b0, '0, 1'b1, 1'b1);
    start = acc_cnt;
    guard = 0;
    while (acc_cnt - start < 64 && guard < 1000) begin
      cycle_a(($urandom_range(0, 3) != 0), DW'($urandom), $urandom_range(0, 1) == 1, 1'b0);
      guard++;
    end
    check_eq("rand_accepted", acc_cnt - start, 64);
    drain_a();

    // Asynchronous reset with beats buffered, then restart at offset 0 col 0
    for (int j = 0; j < 3; j++) cycle_a(1'b1, DW'($urandom), 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", out_valid, 1'b0);
    check_eq("arst_in_ready", in_ready, 1'b1);
    exp_q.delete();
    obs_q.delete();
    n_beat     = 0;
    prev_stall = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    d0 = 24'h5A3C96;
    cycle_a(1'b1, d0, 1'b1, 1'b0);
    for (int j = 0; j < 5; j++) cycle_a(1'b1, DW'($urandom), 1'b1, 1'b0);
    drain_a();
    check_eq("arst_count", obs_q.size(), 6);
    if (obs_q.size() == 6) begin
      check_eq("arst_first_data", obs_q[0].data, 24'h5A3C96);
      check_eq("arst_first_last", obs_q[0].last, 1'b0);
      check_eq("arst_first_primed", obs_q[0].primed, 1'b0);
      check_eq("arst_row1_data", obs_q[4].data, steer({136'd0, obs_q[4].data}, NRB, PW, 0));
    end

    // Instance b: 5 lanes, 2-pixel rows, offsets 0,1,2,3,4,0
    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      if (j > 0) begin
        int row;
        row = (j - 1) / RP_B;
        #1;
        sb = steer({110'd0, hist_b[j-1]}, NRB_B, PW_B, row % NRB_B);
        check_eq("b_valid", ov_b, 1'b1);
        check_eq("b_data", od_b, sb[DW_B-1:0]);
        check_eq("b_last", ol_b, ((j - 1) % RP_B) == RP_B - 1);
        check_eq("b_primed", op_b, row >= NRB_B - 1);
      end
      if (j < 12) begin
        hist_b[j] = {$urandom, $urandom};
        id_b      = hist_b[j];
        iv_b      = 1'b1;
        check_eq("b_in_ready", ir_b, 1'b1);
      end else begin
        iv_b = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
